operation3: RTL and testbench

OPERATION3 -- requirements
Module: operation3

---
 rtl/operation3_if.sv | 24 ++
 rtl/operation3.sv | 117 +++++++++++
 tb/tb_operation3.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/operation3_if.sv
// operation3_if: handshake bundle between the trace block and its neighbours.
// Rev 1.0 -- initial release.
`default_nettype none

interface operation3_if;
  logic        input_tp;
  logic        op2_input_STB;
  logic        op2_BUSY;
  logic [31:0] output_x;
  logic        op2_output_STB;
  logic        output_module_BUSY;

  modport master (
    output input_tp, op2_input_STB, output_module_BUSY,
    input  op2_BUSY, output_x, op2_output_STB
  );

  modport slave (
    input  input_tp, op2_input_STB, output_module_BUSY,
    output op2_BUSY, output_x, op2_output_STB
  );
endinterface

`default_nettype wire

// File: rtl/operation3.sv
// operation3: float32 spike trace, x <- x*2^-DECAY_SHIFT (+1.0 on spike). Macro
// OPERATION3_RESET_TRACE_EN makes a spike set x to exactly 1.0. Rev 1.0 -- initial release.
`default_nettype none

module operation3 #(
  parameter int DECAY_SHIFT = 1
) (
  input  wire logic     clk,
  input  wire logic     rst,
  operation3_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DECAY = 2'd1,
    S_ADD   = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  localparam logic [7:0]  c_SHIFT = 8'(DECAY_SHIFT);
  localparam logic [31:0] c_ONE   = 32'h3F80_0000;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_tp;
  logic        r_add_ph;
  logic [31:0] r_x;
  logic [31:0] r_y;
  logic [31:0] r_out_x;
  logic [31:0] w_y;
  logic [31:0] w_new_x;
  logic        w_accept;

  assign w_accept = (r_state == S_IDLE) && bus.op2_input_STB;

  // Exponent-only decay; anything that would go subnormal is flushed to +0.
  always_comb begin
    w_y = 32'd0;
    if ((r_x != 32'd0) && (r_x[30:23] > c_SHIFT)) begin
      w_y = {1'b0, r_x[30:23] - c_SHIFT, r_x[22:0]};
    end
  end

`ifdef OPERATION3_RESET_TRACE_EN
  assign w_new_x = r_tp ? c_ONE : r_y;
`else
  logic [7:0]  w_shift;
  logic [23:0] w_sig;
  logic [22:0] w_shm;
  logic [22:0] r_shm;

  // y < 1.0, so 1.0+y keeps exponent 127 and only y's aligned significand lands in the mantissa.
  assign w_shift = 8'd127 - r_y[30:23];
  assign w_sig   = {1'b1, r_y[22:0]};

  always_comb begin
    w_shm = 23'd0;
    if ((r_y != 32'd0) && (w_shift < 8'd24)) begin
      w_shm = 23'(w_sig >> w_shift);
    end
  end

  assign w_new_x = r_tp ? {1'b0, 8'd127, r_shm} : r_y;
`endif

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = S_DECAY;
      S_DECAY: w_next_state = S_ADD;
      S_ADD:   if (r_add_ph) w_next_state = S_OUT;
      S_OUT:   if (!bus.output_module_BUSY) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // ADD takes two cycles: the variable shift is registered before the result is formed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_tp     <= 1'b0;
      r_add_ph <= 1'b0;
      r_x      <= 32'd0;
      r_y      <= 32'd0;
      r_out_x  <= 32'd0;
`ifndef OPERATION3_RESET_TRACE_EN
      r_shm    <= 23'd0;
`endif
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE:  if (w_accept) r_tp <= bus.input_tp;
        S_DECAY: r_y <= w_y;
        S_ADD: begin
          if (!r_add_ph) begin
            r_add_ph <= 1'b1;
`ifndef OPERATION3_RESET_TRACE_EN
            r_shm    <= w_shm;
`endif
          end else begin
            r_add_ph <= 1'b0;
            r_x      <= w_new_x;
            r_out_x  <= w_new_x;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.op2_BUSY       = (r_state != S_IDLE);
  assign bus.op2_output_STB = (r_state == S_OUT);
  assign bus.output_x       = r_out_x;

endmodule

`default_nettype wire

// File: tb/tb_operation3.sv
// tb_operation3: directed, table-driven checks of the operation3 trace block.
// Rev 1.0 -- initial release.
`default_nettype none

module tb_operation3;
  localparam int DECAY_SHIFT = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  operation3_if bus ();

  operation3 #(.DECAY_SHIFT(DECAY_SHIFT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        tp;
    int          busy_cycles;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [6];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic wait_idle(input string name);
    int guard = 0;
    @(negedge clk);
    while (bus.op2_BUSY && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check({name, " idle"}, 32'(bus.op2_BUSY), 32'd0);
  endtask

  // Accept one input, check the three-edge latency, hold back-pressure, then complete.
  task automatic send(input logic tp, input int busy_cycles, input logic [31:0] exp, input string name);
    wait_idle(name);
    bus.op2_input_STB      = 1'b1;
    bus.input_tp           = tp;
    bus.output_module_BUSY = (busy_cycles > 0);
    @(negedge clk);
    bus.op2_input_STB = 1'b0;
    check({name, " busy N"}, 32'(bus.op2_BUSY), 32'd1);
    check({name, " stb N"}, 32'(bus.op2_output_STB), 32'd0);
    @(negedge clk);
    check({name, " stb N+1"}, 32'(bus.op2_output_STB), 32'd0);
    @(negedge clk);
    check({name, " stb N+2"}, 32'(bus.op2_output_STB), 32'd0);
    @(negedge clk);
    check({name, " stb N+3"}, 32'(bus.op2_output_STB), 32'd1);
    check({name, " x"}, bus.output_x, exp);
    for (int j = 0; j < busy_cycles; j++) begin
      @(negedge clk);
      check({name, " held stb"}, 32'(bus.op2_output_STB), 32'd1);
      check({name, " held busy"}, 32'(bus.op2_BUSY), 32'd1);
      check({name, " held x"}, bus.output_x, exp);
    end
    bus.output_module_BUSY = 1'b0;
    @(negedge clk);
    check({name, " done stb"}, 32'(bus.op2_output_STB), 32'd0);
    check({name, " done busy"}, 32'(bus.op2_BUSY), 32'd0);
    check({name, " kept x"}, bus.output_x, exp);
  endtask

  // Reset asserted after 'depth' cycles past acceptance (0 = DECAY, 1 = ADD).
  task automatic abort(input int depth, input string name);
    int strobes = 0;
    wait_idle(name);
    bus.op2_input_STB = 1'b1;
    bus.input_tp      = 1'b1;
    @(negedge clk);
    bus.op2_input_STB = 1'b0;
    for (int j = 0; j < depth; j++) @(negedge clk);
    rst = 1'b0;
    #1;
    check({name, " rst stb"}, 32'(bus.op2_output_STB), 32'd0);
    check({name, " rst busy"}, 32'(bus.op2_BUSY), 32'd0);
    check({name, " rst x"}, bus.output_x, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (bus.op2_output_STB) strobes++;
    end
    check({name, " no strobe"}, 32'(strobes), 32'd0);
  endtask

  initial begin
    int acc;
    int outs;
    logic [31:0] exp200;
    logic [31:0] last_x;

`ifdef OPERATION3_RESET_TRACE_EN
    vecs[0] = '{1'b1, 0, 32'h3F80_0000};
    vecs[1] = '{1'b1, 0, 32'h3F80_0000};
    vecs[2] = '{1'b1, 0, 32'h3F80_0000};
    vecs[3] = '{1'b0, 0, 32'h3F00_0000};
    vecs[4] = '{1'b1, 4, 32'h3F80_0000};
    vecs[5] = '{1'b0, 0, 32'h3F00_0000};
`else
    vecs[0] = '{1'b1, 0, 32'h3F80_0000};
    vecs[1] = '{1'b1, 0, 32'h3FC0_0000};
    vecs[2] = '{1'b1, 0, 32'h3FE0_0000};
    vecs[3] = '{1'b0, 0, 32'h3F60_0000};
    vecs[4] = '{1'b1, 4, 32'h3FB8_0000};
    vecs[5] = '{1'b0, 0, 32'h3F38_0000};
`endif

    bus.input_tp           = 1'b0;
    bus.op2_input_STB      = 1'b0;
    bus.output_module_BUSY = 1'b0;

    #2 rst = 1'b0;
    #1;
    check("reset stb", 32'(bus.op2_output_STB), 32'd0);
    check("reset busy", 32'(bus.op2_BUSY), 32'd0);
    check("reset x", bus.output_x, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      send(vecs[i].tp, vecs[i].busy_cycles, vecs[i].exp, $sformatf("vec%0d", i));
    end

    abort(0, "abort decay");
    send(1'b1, 0, 32'h3F80_0000, "after abort decay");
    abort(1, "abort add");
    send(1'b1, 0, 32'h3F80_0000, "after abort add");

    for (int k = 1; k <= 200; k++) begin
      exp200 = (k <= 126) ? {1'b0, 8'(127 - k), 23'd0} : 32'd0;
      send(1'b0, 0, exp200, $sformatf("halve%0d", k));
    end

    // Strobe held high: one acceptance per IDLE visit, five cycles per round trip.
    wait_idle("stream");
    bus.op2_input_STB = 1'b1;
    bus.input_tp      = 1'b1;
    acc    = 0;
    outs   = 0;
    last_x = 32'd0;
    for (int i = 0; i < 40; i++) begin
      if (!bus.op2_BUSY) acc++;
      if (bus.op2_output_STB) begin
        outs++;
        last_x = bus.output_x;
      end
      @(negedge clk);
    end
    bus.op2_input_STB = 1'b0;
    check("stream accepts", 32'(acc), 32'd8);
    check("stream outputs", 32'(outs), 32'd8);
`ifdef OPERATION3_RESET_TRACE_EN
    check("stream last x", last_x, 32'h3F80_0000);
`else
    check("stream last x", last_x, 32'h3FFF_0000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
